// File: rtl/memory_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths and
// the access FSM state encoding.
package memory_pkg;

    localparam int WORD_SIZE_DEFAULT = 8;
    localparam int LEN_LOG_2_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// the port that was not granted last.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a fetch port (m0) and a load/store port (m1) onto a single
// memory with combinational read data; every access takes IDLE/ACCESS/RESP.
import memory_pkg::*;

module memory_arbiter #(
    parameter int word_size = WORD_SIZE_DEFAULT,
    parameter int len_log_2 = LEN_LOG_2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m1_req,
    input  logic                 m0_we,
    input  logic                 m1_we,
    input  logic [len_log_2-1:0] m0_addr,
    input  logic [len_log_2-1:0] m1_addr,
    input  logic [word_size-1:0] m0_wdata,
    input  logic [word_size-1:0] m1_wdata,
    output logic                 m0_ack,
    output logic                 m1_ack,
    output logic [word_size-1:0] m0_rdata,
    output logic [word_size-1:0] m1_rdata,
    output logic [len_log_2-1:0] mem_addr,
    output logic [word_size-1:0] mem_data_in,
    output logic                 mem_we,
    output logic                 busy,
    input  logic [word_size-1:0] mem_data_out
);

    state_t                 state;
    state_t                 next_state;
    logic                   any_req;
    logic                   grant;
    logic                   last;
    logic                   lat_id;
    logic                   lat_we;
    logic [len_log_2-1:0]   lat_addr;
    logic [word_size-1:0]   lat_wdata;

    assign any_req = m0_req | m1_req;

    rr_arbiter_2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Last-granted resets to port 1 so that port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                last      <= grant;
                lat_id    <= grant;
                lat_we    <= grant ? m1_we    : m0_we;
                lat_addr  <= grant ? m1_addr  : m0_addr;
                lat_wdata <= grant ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS && !lat_we) begin
                if (lat_id) begin
                    m1_rdata <= mem_data_out;
                end else begin
                    m0_rdata <= mem_data_out;
                end
            end
        end
    end

    assign mem_addr    = lat_addr;
    assign mem_data_in = lat_wdata;

    // The reset term keeps a reset landing mid-ACCESS from writing memory.
    always_comb begin
        busy   = (state != IDLE);
        mem_we = (state == ACCESS) && lat_we && !reset;
        m0_ack = (state == RESP) && !lat_id;
        m1_ack = (state == RESP) && lat_id;
    end

endmodule
